// File: rtl/core_ahb_pkg.sv
// Shared AHB-Lite encodings and cache line-transfer FSM states.
package core_ahb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_LAST  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [3:0] HPROT_DATA = 4'b0011;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
  } line_req_t;

  function automatic logic [2:0] hburst_for(input int beats);
    case (beats)
      1:       return HBURST_SINGLE;
      4:       return HBURST_INCR4;
      default: return HBURST_INCR8;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Two-port round-robin picker; grant is combinational, last-grant updates on load.
// A tie goes to the port that did not win last time (I is assumed last out of reset).
module ahb_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic load,
  output logic gnt_d,
  output logic any_req
);

  logic last_d;

  assign any_req = i_req | d_req;
  assign gnt_d   = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_d <= 1'b0;
    else if (load)
      last_d <= gnt_d;
  end

endmodule

// File: rtl/cache_ahb_arbiter.sv
// I/D cache line-transfer arbiter onto one AHB-Lite master port; grant one cycle after request.
// HREADY low stalls address/data in place; strobes go only to the granted cache.
module cache_ahb_arbiter
  import core_ahb_pkg::*;
#(
  parameter int BEATS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        d_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] d_addr,
  input  logic        i_we,
  input  logic        d_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] d_wdata,
  output logic        i_wnext,
  output logic        d_wnext,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  output logic        i_done,
  output logic        d_done,
  output logic        i_err,
  output logic        d_err,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS);

  logic [2:0]    state;
  logic          gnt_q;
  logic [CW-1:0] cnt;
  logic [31:0]   haddr_q;
  logic          hwrite_q;
  logic [2:0]    hburst_q;
  logic          done_q;
  logic          err_q;
  logic          arb_gnt_d;
  logic          any_req;
  logic          data_ph;
  logic          beat_ok;
  line_req_t     sel_req;

  // The finishing port still holds req during its done cycle; that is not a new request.
  ahb_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req & ~(done_q & ~gnt_q)),
    .d_req   (d_req & ~(done_q & gnt_q)),
    .load    (state == ST_IDLE),
    .gnt_d   (arb_gnt_d),
    .any_req (any_req)
  );

  assign sel_req = arb_gnt_d ? '{addr: d_addr, we: d_we} : '{addr: i_addr, we: i_we};

  assign data_ph = (state == ST_BURST) || (state == ST_LAST);
  assign beat_ok = data_ph & HREADY & ~HRESP;

  assign i_rvalid = beat_ok & ~hwrite_q & ~gnt_q;
  assign d_rvalid = beat_ok & ~hwrite_q & gnt_q;
  assign i_wnext  = beat_ok & hwrite_q & ~gnt_q;
  assign d_wnext  = beat_ok & hwrite_q & gnt_q;
  assign rdata    = HRDATA;
  assign i_done   = done_q & ~gnt_q;
  assign d_done   = done_q & gnt_q;
  assign i_err    = err_q & ~gnt_q;
  assign d_err    = err_q & gnt_q;

  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HBURST    = hburst_q;
  assign HSIZE     = HSIZE_WORD;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = (hwrite_q && (data_ph || state == ST_ERR)) ?
                     (gnt_q ? d_wdata : i_wdata) : 32'd0;

  always_comb begin
    HTRANS = HTRANS_IDLE;
    case (state)
      ST_ADDR:  HTRANS = HTRANS_NONSEQ;
      ST_BURST: HTRANS = HTRANS_SEQ;
      default:  HTRANS = HTRANS_IDLE;
    endcase
  end

  // cnt tracks the beat whose address phase is currently on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt_q    <= 1'b0;
      cnt      <= '0;
      haddr_q  <= 32'd0;
      hwrite_q <= 1'b0;
      hburst_q <= HBURST_SINGLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: if (any_req) begin
          gnt_q    <= arb_gnt_d;
          haddr_q  <= sel_req.addr;
          hwrite_q <= sel_req.we;
          hburst_q <= hburst_for(BEATS);
          cnt      <= CW'(1);
          state    <= ST_ADDR;
        end
        ST_ADDR: if (HREADY) begin
          if (cnt == LAST_BEAT) begin
            state <= ST_LAST;
          end else begin
            state   <= ST_BURST;
            cnt     <= cnt + 1'b1;
            haddr_q <= haddr_q + 32'd4;
          end
        end
        ST_BURST: begin
          if (HRESP) begin
            state <= ST_ERR;
          end else if (HREADY) begin
            if (cnt == LAST_BEAT) begin
              state <= ST_LAST;
            end else begin
              cnt     <= cnt + 1'b1;
              haddr_q <= haddr_q + 32'd4;
            end
          end
        end
        ST_LAST: begin
          if (HRESP) begin
            state <= ST_ERR;
          end else if (HREADY) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_ERR: if (HREADY) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ahb_arbiter.sv
// Random I/D line traffic against a transaction-level cache/slave model with stalls and errors.
module tb_cache_ahb_arbiter;

  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, i_we, d_we;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic        i_wnext, d_wnext, i_rvalid, d_rvalid, i_done, d_done, i_err, d_err;
  logic [31:0] rdata, HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;

  always #5 clk = ~clk;

  cache_ahb_arbiter #(.BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .d_req(d_req), .i_addr(i_addr), .d_addr(d_addr),
    .i_we(i_we), .d_we(d_we), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_wnext(i_wnext), .d_wnext(d_wnext), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .rdata(rdata), .i_done(i_done), .d_done(d_done), .i_err(i_err), .d_err(d_err),
    .HADDR(HADDR), .HBURST(HBURST), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave memory and requester / transfer model (index 0 = I-cache, 1 = D-cache)
  logic [31:0] mem [0:1023];
  bit          req [2];
  logic [31:0] addr_m [2];
  logic [31:0] tag [2];
  bit          we_m [2];
  int          wbeat [2];
  int          gap [2];
  bit          done_prev [2];
  bit          pend_prev [2];
  bit          active, dp_vld, exp_done, exp_err, stall_en, err_en;
  int          owner, last_win, acc_cnt, data_cnt, err_beat, err_stage, dp_beat, stuck;
  logic [31:0] dp_addr;

  task automatic drive_ports();
    i_req = req[0]; i_addr = addr_m[0]; i_we = we_m[0]; i_wdata = tag[0] + wbeat[0];
    d_req = req[1]; d_addr = addr_m[1]; d_we = we_m[1]; d_wdata = tag[1] + wbeat[1];
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; addr_m[p] = 0; tag[p] = 0; we_m[p] = 0; wbeat[p] = 0;
      gap[p] = 0; done_prev[p] = 0; pend_prev[p] = 0;
    end
    active = 0; dp_vld = 0; exp_done = 0; exp_err = 0;
    owner = 0; last_win = 0; acc_cnt = 0; data_cnt = 0;
    err_beat = 0; err_stage = 0; dp_beat = 0; stuck = 0;
  endtask

  task automatic step();
    logic [1:0] exp_tr;
    int         w;
    bit         exp_rv, exp_wn;
    @(negedge clk);
    // Requesters: drop req the cycle after done, then re-request after a short gap.
    for (int p = 0; p < 2; p++) begin
      if (done_prev[p]) begin
        req[p] = 0; done_prev[p] = 0; gap[p] = $urandom_range(0, 3);
      end else if (!req[p]) begin
        if (gap[p] == 0) begin
          req[p] = 1; addr_m[p] = $urandom_range(0, 127) * 32;
          we_m[p] = ($urandom_range(0, 1) == 1); tag[p] = $urandom; wbeat[p] = 0;
        end else gap[p]--;
      end
    end
    drive_ports();

    if (!active && HTRANS != 2'b00) begin
      w = (pend_prev[0] && pend_prev[1]) ? 1 - last_win : (pend_prev[1] ? 1 : 0);
      check_eq("grant_pending", pend_prev[w], 1);
      check_eq("grant_addr", HADDR, addr_m[w]);
      check_eq("grant_we", HWRITE, we_m[w]);
      active = 1; owner = w; last_win = w; acc_cnt = 0; data_cnt = 0; err_stage = 0;
      err_beat = (err_en && $urandom_range(0, 3) == 0) ? $urandom_range(1, BEATS) : 0;
    end
    if (active) begin
      exp_tr = (err_stage != 0 || acc_cnt >= BEATS) ? 2'b00 : (acc_cnt == 0 ? 2'b10 : 2'b11);
      check_eq("htrans", HTRANS, exp_tr);
      if (exp_tr != 2'b00) begin
        check_eq("haddr", HADDR, addr_m[owner] + 32'(4 * acc_cnt));
        check_eq("hwrite", HWRITE, we_m[owner]);
        check_eq("hctrl", {HBURST, HSIZE, HPROT, HMASTLOCK}, {3'b101, 3'b010, 4'b0011, 1'b0});
      end
    end
    check_eq("i_done", i_done, exp_done && owner == 0);
    check_eq("d_done", d_done, exp_done && owner == 1);
    check_eq("i_err", i_err, exp_err && owner == 0);
    check_eq("d_err", d_err, exp_err && owner == 1);
    if (exp_done) begin active = 0; stuck = 0; end
    if (i_done) done_prev[0] = 1;
    if (d_done) done_prev[1] = 1;

    // Slave response for the data phase in progress this cycle
    if (dp_vld && err_stage == 1) begin
      HREADY = 1; HRESP = 1;
    end else if (dp_vld && err_stage == 0 && dp_beat == err_beat) begin
      HREADY = 0; HRESP = 1;
    end else if (dp_vld) begin
      HREADY = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1; HRESP = 0;
    end else begin
      HREADY = 1; HRESP = 0;
    end
    HRDATA = (dp_vld && !we_m[owner]) ? mem[dp_addr[11:2]] : $urandom;
    #1;
    exp_rv = dp_vld && HREADY && !HRESP && !we_m[owner];
    exp_wn = dp_vld && HREADY && !HRESP && we_m[owner];
    check_eq("i_rvalid", i_rvalid, exp_rv && owner == 0);
    check_eq("d_rvalid", d_rvalid, exp_rv && owner == 1);
    check_eq("i_wnext", i_wnext, exp_wn && owner == 0);
    check_eq("d_wnext", d_wnext, exp_wn && owner == 1);
    if (exp_rv) check_eq("rdata", rdata, mem[dp_addr[11:2]]);
    if (dp_vld && we_m[owner] && err_stage == 0)
      check_eq("hwdata", HWDATA, tag[owner] + 32'(data_cnt));
    if (i_wnext) wbeat[0]++;
    if (d_wnext) wbeat[1]++;

    // What the clock edge does to the bus-level transfer
    exp_done = 0; exp_err = 0;
    if (dp_vld) begin
      if (err_stage == 1) begin
        exp_done = 1; exp_err = 1; dp_vld = 0; err_stage = 2;
      end else if (HRESP) begin
        err_stage = 1;
      end else if (HREADY) begin
        if (we_m[owner]) mem[dp_addr[11:2]] = tag[owner] + 32'(data_cnt);
        data_cnt++; dp_vld = 0;
        if (data_cnt == BEATS) exp_done = 1;
      end
    end
    if (active && err_stage == 0 && HTRANS[1] && HREADY) begin
      dp_vld = 1; dp_addr = HADDR; acc_cnt++; dp_beat = acc_cnt;
    end
    pend_prev[0] = req[0] && !i_done;
    pend_prev[1] = req[1] && !d_done;
    stuck++;
    if (stuck >= 300) begin
      check_eq("watchdog_cycles_without_done", stuck, 0);
      stuck = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    model_reset();
    drive_ports();
    HREADY = 1; HRESP = 0; HRDATA = 0;
    stall_en = 0; err_en = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    check_eq("rst_htrans", HTRANS, 2'b00);
    check_eq("rst_haddr", HADDR, 32'd0);
    check_eq("rst_hburst", HBURST, 3'b000);
    check_eq("rst_hwrite", HWRITE, 1'b0);
    check_eq("rst_hwdata", HWDATA, 32'd0);
    check_eq("rst_strobes", {i_wnext, d_wnext, i_rvalid, d_rvalid, i_done, d_done, i_err, d_err}, 8'd0);
    reset = 0;

    repeat (600) step();
    stall_en = 1; err_en = 1;
    repeat (1500) step();

    // Reset in the middle of a burst, then a clean restart
    err_en = 0;
    for (int k = 0; k < 400 && !(active && acc_cnt >= 5 && err_stage == 0); k++) step();
    check_eq("midburst_reached", active && acc_cnt >= 5, 1);
    #2 reset = 1;
    #1;
    check_eq("async_rst_htrans", HTRANS, 2'b00);
    check_eq("async_rst_haddr", HADDR, 32'd0);
    check_eq("async_rst_hwdata", HWDATA, 32'd0);
    check_eq("async_rst_strobes", {i_wnext, d_wnext, i_rvalid, d_rvalid, i_done, d_done, i_err, d_err}, 8'd0);
    model_reset();
    drive_ports();
    HREADY = 1; HRESP = 0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_no_done", {i_done, d_done, i_err, d_err}, 4'd0);
    end
    reset = 0;
    stall_en = 0;
    repeat (300) step();
    stall_en = 1; err_en = 1;
    repeat (300) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ahb_arbiter.md
CACHE_AHB_ARBITER -- requirements
Module: cache_ahb_arbiter

Interface
REQ-001 SHALL provide parameter BEATS, default 8: words per line transfer; legal values 1, 4, 8.
REQ-002 SHALL provide clk  input  1  clock; all logic rising-edge.
REQ-003 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide i_req / d_req  input  1  each  line-transfer request from I-cache / D-cache, held until done.
REQ-005 SHALL provide i_addr / d_addr  input  32  each  line-aligned start address.
REQ-006 SHALL provide i_we / d_we  input  1  each  1 = line write (evict), 0 = line fill.
REQ-007 SHALL provide i_wdata / d_wdata  input  32  each  current write beat from requester.
REQ-008 SHALL provide i_wnext / d_wnext  output  1  each  write beat consumed; requester advances wdata next cycle.
REQ-009 SHALL provide i_rvalid / d_rvalid  output  1  each  read beat valid; rdata  output  32  shared read data.
REQ-010 SHALL provide i_done / d_done, i_err / d_err  output  1  each  transfer complete / terminated by HRESP error.
REQ-011 SHALL provide AHB-Lite master outputs HADDR 32, HBURST 3, HTRANS 2, HWRITE 1, HSIZE 3, HPROT 4, HMASTLOCK 1, HWDATA 32; inputs HRDATA 32, HREADY 1, HRESP 1.

Function
REQ-012 FSM states: IDLE, ADDR (first beat NONSEQ), BURST (SEQ beats), LAST (final data phase only), ERR.
REQ-013 IDLE: with any req, grant registered; next cycle ADDR drives HTRANS=NONSEQ, HADDR=granted addr.
REQ-014 Arbitration round-robin: tie at IDLE goes to port not granted last; first tie after reset goes to D.
REQ-015 Grant held from ADDR until done; req deassertion mid-burst ignored.
REQ-016 HBURST = SINGLE (000) for BEATS=1, INCR4 (011) for 4, INCR8 (101) for 8; HSIZE=010, HPROT=0011, HMASTLOCK=0 constant.
REQ-017 Address phases beats 2..BEATS: HTRANS=SEQ, HADDR=previous+4; address phase of beat n+1 overlaps data phase of beat n.
REQ-018 HREADY=0: HADDR, HTRANS, HWRITE, HWDATA held; no strobe issued.
REQ-019 Read data phase with HREADY=1, HRESP=0: rvalid of granted port pulses one cycle, rdata = HRDATA that cycle.
REQ-020 Write: HWDATA = granted port wdata during each data phase; wnext pulses on each data phase with HREADY=1.
REQ-021 After last address phase, HTRANS=IDLE; LAST waits for final HREADY=1, then done pulses one cycle, FSM -> IDLE.
REQ-022 Back-to-back: new grant in IDLE cycle after done; minimum one IDLE bus cycle between transfers.
REQ-023 HRESP=1 with HREADY=0 (error cycle 1): HTRANS forced IDLE next cycle, FSM -> ERR; on HREADY=1 done and err pulse together, remaining beats dropped.
REQ-024 Beat counter width clog2(BEATS)+1; no HADDR wrap, line alignment guarantees no 1 KB crossing.
REQ-025 Strobes (wnext, rvalid, done, err) only to granted port; other port's always 0.

Reset
REQ-026 Reset asserted: HTRANS=00, HADDR=0, HBURST=000, HWRITE=0, HWDATA=0, all strobes 0, FSM=IDLE, last-grant=I, immediately (asynchronous).
REQ-027 Reset mid-burst abandons transfer; no done/err issued.

Structure
REQ-028 FSM state encoding, HTRANS/HBURST/HSIZE constants in shared package core_ahb_pkg.
REQ-029 Single sub-module ahb_rr_arbiter (2-port round-robin grant with last-grant register); rest inline.

Verification
REQ-030 D read BEATS=8 at 0x100, HREADY=1: NONSEQ 0x100, SEQ 0x104..0x11C, 8 d_rvalid pulses, d_done one cycle after 8th beat.
REQ-031 i_req and d_req same cycle after reset: D granted first, I granted in IDLE cycle after d_done; next tie goes to D.
REQ-032 I read with HREADY low 2 cycles on beat 3: HADDR 0x...08 held 2 cycles, exactly 8 i_rvalid, data order preserved.
REQ-033 D write 0x200, wdata 0xA0..0xA7 advanced on d_wnext: HWDATA sequence 0xA0..0xA7 in data phases, HWRITE=1.
REQ-034 HRESP error on beat 4 of D read: HTRANS=IDLE after error cycle 1, d_done and d_err pulse together, 3 d_rvalid total.
REQ-035 Reset asserted mid-burst beat 5: HTRANS=00 same cycle, no done; post-reset request completes normally.
